// File: rtl/weak_classifier_eval_pkg.sv
// Shared cascade constants: stage geometry, datapath widths and FSM state type.
// Imported by the weak-classifier evaluator, its bus interface and the stage accumulator.
// Ports: none (package only).
package cascade_pkg;

  localparam int STAGE_NUM     = 25;
  localparam int MAX_WEAKCOUNT = 211;

  // Datapath widths shared with the stage accumulator.
  localparam int FEATURE_W   = 24;
  localparam int STD_W       = 16;
  localparam int THRESHOLD_W = 13;
  localparam int LEAF_W      = 13;
  localparam int STAGE_IDX_W = $clog2(STAGE_NUM);
  localparam int WC_IDX_W    = $clog2(MAX_WEAKCOUNT);

  // Weak classifiers per stage, stage 0 first.
  localparam int STAGE_WEAKCOUNT [STAGE_NUM] = '{
    3, 4, 9, 16, 27, 32, 52, 53, 62, 72, 83, 91, 99,
    115, 127, 135, 136, 137, 159, 155, 169, 196, 197, 181, 211
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Width that holds both the feature sum and the full threshold x {0,std}
  // product, so the compare never truncates.
  function automatic int cmp_width(input int w_feat, input int w_thr, input int w_std);
    int w_prod;
    w_prod = w_thr + w_std + 1;
    return (w_feat > w_prod) ? w_feat : w_prod;
  endfunction

endpackage

// File: rtl/weak_classifier_eval_if.sv
// Bus between the feature fetcher (master) and the weak-classifier evaluator (slave).
// Carries the std-dev handshake, the feature bundle handshake, the leaf output
// handshake, the window-resolved pulse and the upstream address indices.
interface weak_classifier_eval_if
  import cascade_pkg::*;
#(
  parameter int W_FEATURE      = FEATURE_W,
  parameter int W_STD          = STD_W,
  parameter int W_WC_THRESHOLD = THRESHOLD_W,
  parameter int W_LEAF         = LEAF_W
) ();

  logic                              std_valid;
  logic                              std_ready;
  logic        [W_STD-1:0]           std_data;

  logic                              feat_valid;
  logic                              feat_ready;
  logic signed [W_FEATURE-1:0]       feat_sum;
  logic signed [W_WC_THRESHOLD-1:0]  feat_threshold;
  logic signed [W_LEAF-1:0]          feat_leaf_left;
  logic signed [W_LEAF-1:0]          feat_leaf_right;

  logic                              leaf_valid;
  logic                              leaf_ready;
  logic signed [W_LEAF-1:0]          leaf_data;
  logic                              leaf_eot;

  logic                              win_done;
  logic        [STAGE_IDX_W-1:0]     stage_idx;
  logic        [WC_IDX_W-1:0]        wc_idx;

  modport master (
    output std_valid, std_data,
    output feat_valid, feat_sum, feat_threshold, feat_leaf_left, feat_leaf_right,
    output leaf_ready, win_done,
    input  std_ready, feat_ready, leaf_valid, leaf_data, leaf_eot, stage_idx, wc_idx
  );

  modport slave (
    input  std_valid, std_data,
    input  feat_valid, feat_sum, feat_threshold, feat_leaf_left, feat_leaf_right,
    input  leaf_ready, win_done,
    output std_ready, feat_ready, leaf_valid, leaf_data, leaf_eot, stage_idx, wc_idx
  );

endinterface

// File: rtl/weak_classifier_eval_wc_compare_pipe.sv
// Two-stage datapath: S1 registers threshold x std and the sign-extended sum, S2 selects the leaf.
// Latency 2 cycles from input handshake to out_valid; one result per cycle at full rate.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready drops once both stages are full.
// Ports: clk/rst, flush (drops both stages), in_* bundle with valid/ready, out_* leaf with valid/ready.
module wc_compare_pipe
  import cascade_pkg::*;
#(
  parameter int W_FEATURE      = FEATURE_W,
  parameter int W_STD          = STD_W,
  parameter int W_WC_THRESHOLD = THRESHOLD_W,
  parameter int W_LEAF         = LEAF_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [W_FEATURE-1:0]       in_sum,
  input  logic signed [W_WC_THRESHOLD-1:0]  in_threshold,
  input  logic        [W_STD-1:0]           in_std,
  input  logic signed [W_LEAF-1:0]          in_left,
  input  logic signed [W_LEAF-1:0]          in_right,
  input  logic                              in_eot,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [W_LEAF-1:0]          out_leaf,
  output logic                              out_eot
);

  localparam int W_CMP = cmp_width(W_FEATURE, W_WC_THRESHOLD, W_STD);

  logic                      s1_valid;
  logic signed [W_CMP-1:0]   s1_prod;
  logic signed [W_CMP-1:0]   s1_sum;
  logic signed [W_LEAF-1:0]  s1_left;
  logic signed [W_LEAF-1:0]  s1_right;
  logic                      s1_eot;

  logic                      s2_load;
  logic                      s1_adv;
  logic signed [W_CMP-1:0]   thr_x;
  logic signed [W_CMP-1:0]   std_x;
  logic signed [W_CMP-1:0]   prod;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = s1_adv;

  // Std-dev is unsigned: a zero MSB keeps it positive in the signed multiply.
  assign thr_x = W_CMP'(in_threshold);
  assign std_x = W_CMP'({1'b0, in_std});
  assign prod  = thr_x * std_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_leaf  <= '0;
      out_eot   <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_load) out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        // Equality falls through to the right leaf.
        out_leaf <= (s1_sum < s1_prod) ? s1_left : s1_right;
        out_eot  <= s1_eot;
      end
    end
  end

  // Payload registers need no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_prod  <= prod;
      s1_sum   <= W_CMP'(in_sum);
      s1_left  <= in_left;
      s1_right <= in_right;
      s1_eot   <= in_eot;
    end
  end

endmodule

// File: rtl/weak_classifier_eval.sv
// Weak-classifier evaluator: threshold x std compare per feature, emits the chosen leaf with stage eot.
// Latency 2 cycles from feature accept to leaf_valid; 1 leaf/cycle with leaf_ready held high.
// Backpressure: feat_ready drops when both pipe stages are full; win_done flushes and returns to IDLE.
// Ports: clk, rst (sync, active-high) and the slave side of weak_classifier_eval_if.
module weak_classifier_eval
  import cascade_pkg::*;
#(
  parameter int W_FEATURE      = FEATURE_W,
  parameter int W_STD          = STD_W,
  parameter int W_WC_THRESHOLD = THRESHOLD_W,
  parameter int W_LEAF         = LEAF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  weak_classifier_eval_if.slave bus
);

  state_t                    state;
  logic [STAGE_IDX_W-1:0]    stage_cnt;
  logic [WC_IDX_W-1:0]       wc_cnt;
  logic [W_STD-1:0]          std_reg;

  logic                      pipe_in_ready;
  logic                      std_fire;
  logic                      feat_fire;
  logic [WC_IDX_W-1:0]       last_wc_idx;
  logic                      last_wc;
  logic                      last_stage;

  // Table lookup with constant indices only, so the stage counter never
  // indexes past the end of the weak-count table.
  always_comb begin
    last_wc_idx = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      if (int'(stage_cnt) == s) last_wc_idx = WC_IDX_W'(STAGE_WEAKCOUNT[s] - 1);
    end
  end

  assign last_wc    = (wc_cnt == last_wc_idx);
  assign last_stage = (stage_cnt == STAGE_IDX_W'(STAGE_NUM - 1));

  assign bus.std_ready  = (state == IDLE);
  assign bus.feat_ready = (state == RUN) && pipe_in_ready;

  // win_done swallows any handshake offered in the same cycle.
  assign std_fire  = bus.std_valid && bus.std_ready && !bus.win_done;
  assign feat_fire = bus.feat_valid && bus.feat_ready && !bus.win_done;

  assign bus.stage_idx = stage_cnt;
  assign bus.wc_idx    = wc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stage_cnt <= '0;
      wc_cnt    <= '0;
      std_reg   <= '0;
    end else if (bus.win_done) begin
      state     <= IDLE;
      stage_cnt <= '0;
      wc_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (std_fire) begin
            std_reg <= bus.std_data;
            state   <= RUN;
          end
        end
        RUN: begin
          if (feat_fire) begin
            if (last_wc) begin
              wc_cnt <= '0;
              // The final stage parks its counter; DONE marks completion.
              if (last_stage) state <= DONE;
              else            stage_cnt <= stage_cnt + STAGE_IDX_W'(1);
            end else begin
              wc_cnt <= wc_cnt + WC_IDX_W'(1);
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  wc_compare_pipe #(
    .W_FEATURE      (W_FEATURE),
    .W_STD          (W_STD),
    .W_WC_THRESHOLD (W_WC_THRESHOLD),
    .W_LEAF         (W_LEAF)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.win_done),
    .in_valid     (feat_fire),
    .in_ready     (pipe_in_ready),
    .in_sum       (bus.feat_sum),
    .in_threshold (bus.feat_threshold),
    .in_std       (std_reg),
    .in_left      (bus.feat_leaf_left),
    .in_right     (bus.feat_leaf_right),
    .in_eot       (last_wc),
    .out_valid    (bus.leaf_valid),
    .out_ready    (bus.leaf_ready),
    .out_leaf     (bus.leaf_data),
    .out_eot      (bus.leaf_eot)
  );

endmodule

// File: tb/tb_weak_classifier_eval.sv
// Self-checking bench for weak_classifier_eval: directed vector table, stage/backpressure/reject/reset
// sequences and a randomized full-cascade run scored against a queue-based reference model.
module tb_weak_classifier_eval;
  import cascade_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weak_classifier_eval_if bus ();

  weak_classifier_eval dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [LEAF_W-1:0] leaf;
    logic                     eot;
  } exp_t;

  typedef struct {
    logic        [STD_W-1:0]       std;
    logic signed [THRESHOLD_W-1:0] thr;
    logic signed [FEATURE_W-1:0]   sum;
    logic signed [LEAF_W-1:0]      left;
    logic signed [LEAF_W-1:0]      right;
    logic signed [LEAF_W-1:0]      exp_leaf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_leaf = 0;
  int total = 0;
  int pre[STAGE_NUM+1];
  logic [STD_W-1:0] cur_std = '0;
  bit hold_prev = 0;
  logic signed [LEAF_W-1:0] hold_leaf;
  logic hold_eot;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: leaf is left when sum is strictly below threshold*std.
  function automatic longint model_leaf(input longint sum, input longint thr, input longint sd,
                                        input longint l, input longint r);
    return (sum < thr * sd) ? l : r;
  endfunction

  // The n-th feature of a window closes a stage when n+1 is a running total of stage sizes.
  function automatic bit model_eot(input int n);
    for (int s = 0; s < STAGE_NUM; s++) if (pre[s+1] - 1 == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_pos(input int n, output int st, output int wc);
    st = STAGE_NUM - 1;
    wc = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (n >= pre[s] && n < pre[s+1]) begin
        st = s;
        wc = n - pre[s];
      end
  endfunction

  // One clock: observe handshakes at the falling edge, then advance past the rising edge.
  task automatic step();
    int st, wc;
    exp_t e;
    @(negedge clk);
    if (rst || bus.win_done) begin
      sb.delete();
      n_acc = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_leaf", bus.leaf_data, hold_leaf);
        chk("hold_eot", bus.leaf_eot, hold_eot);
      end
      if (bus.std_valid && bus.std_ready) cur_std = bus.std_data;
      if (bus.feat_valid && bus.feat_ready) begin
        model_pos(n_acc, st, wc);
        chk("stage_idx", bus.stage_idx, st);
        chk("wc_idx", bus.wc_idx, wc);
        e.leaf = LEAF_W'(model_leaf(bus.feat_sum, bus.feat_threshold, cur_std,
                                    bus.feat_leaf_left, bus.feat_leaf_right));
        e.eot = model_eot(n_acc);
        sb.push_back(e);
        n_acc++;
      end
      if (bus.leaf_valid && bus.leaf_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_leaf", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("leaf_data", bus.leaf_data, e.leaf);
          chk("leaf_eot", bus.leaf_eot, e.eot);
          n_leaf++;
        end
      end
      hold_prev = bus.leaf_valid && !bus.leaf_ready;
      hold_leaf = bus.leaf_data;
      hold_eot  = bus.leaf_eot;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_feat();
    longint p, s;
    bus.feat_threshold  = THRESHOLD_W'($urandom);
    bus.feat_leaf_left  = LEAF_W'($urandom);
    bus.feat_leaf_right = LEAF_W'($urandom);
    p = longint'(bus.feat_threshold) * longint'(cur_std);
    if ($urandom_range(1) == 0) s = p + longint'($urandom_range(4)) - 2;
    else                        s = longint'($signed(FEATURE_W'($urandom)));
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    bus.feat_sum = FEATURE_W'(s);
  endtask

  task automatic start_window(input logic [STD_W-1:0] sd);
    bus.win_done = 1'b1;
    step();
    bus.win_done = 1'b0;
    bus.std_data  = sd;
    bus.std_valid = 1'b1;
    step();
    bus.std_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc, cyc;
    pre[0] = 0;
    for (int s = 0; s < STAGE_NUM; s++) pre[s+1] = pre[s] + STAGE_WEAKCOUNT[s];
    total = pre[STAGE_NUM];

    tbl[0] = '{16'd100,   13'sd5,     24'sd499,      13'sd11,    -13'sd22,  13'sd11};
    tbl[1] = '{16'd100,   13'sd5,     24'sd500,      13'sd11,    -13'sd22, -13'sd22};
    tbl[2] = '{16'd100,  -13'sd5,    -24'sd600,      13'sd33,     13'sd44,  13'sd33};
    tbl[3] = '{16'd100,  -13'sd5,    -24'sd500,      13'sd33,     13'sd44,  13'sd44};
    tbl[4] = '{16'd65535, 13'sd4095,  24'sd8388607, -13'sd4096,   13'sd4095, -13'sd4096};
    tbl[5] = '{16'd65535,-13'sd4096, -24'sd8388608,  13'sd1,      13'sd2,   13'sd2};
    tbl[6] = '{16'd0,    -13'sd4096, -24'sd1,        13'sd7,      13'sd8,   13'sd7};
    tbl[7] = '{16'd1,     13'sd1,     24'sd0,        13'sd5,      13'sd6,   13'sd5};

    rst = 1'b1;
    bus.std_valid = 1'b0; bus.std_data = '0;
    bus.feat_valid = 1'b0; bus.feat_sum = '0; bus.feat_threshold = '0;
    bus.feat_leaf_left = '0; bus.feat_leaf_right = '0;
    bus.leaf_ready = 1'b1; bus.win_done = 1'b0;
    repeat (3) step();
    chk("rst_std_ready", bus.std_ready, 1);
    chk("rst_feat_ready", bus.feat_ready, 0);
    chk("rst_leaf_valid", bus.leaf_valid, 0);
    chk("rst_leaf_eot", bus.leaf_eot, 0);
    chk("rst_leaf_data", bus.leaf_data, 0);
    chk("rst_stage_idx", bus.stage_idx, 0);
    chk("rst_wc_idx", bus.wc_idx, 0);
    rst = 1'b0;

    // Directed selection vectors, each in a fresh window.
    for (int i = 0; i < 8; i++) begin
      start_window(tbl[i].std);
      bus.feat_sum = tbl[i].sum;
      bus.feat_threshold = tbl[i].thr;
      bus.feat_leaf_left = tbl[i].left;
      bus.feat_leaf_right = tbl[i].right;
      bus.feat_valid = 1'b1;
      chk("tbl_feat_ready", bus.feat_ready, 1);
      step();
      bus.feat_valid = 1'b0;
      chk("tbl_lat1_valid", bus.leaf_valid, 0);
      step();
      chk("tbl_lat2_valid", bus.leaf_valid, 1);
      chk("tbl_leaf", bus.leaf_data, tbl[i].exp_leaf);
      chk("tbl_eot", bus.leaf_eot, 0);
      step();
    end

    // Stage boundary: 7 features across stages 0 (3 WCs) and 1 (4 WCs).
    start_window(STD_W'($urandom));
    base = n_leaf;
    bus.leaf_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_feat();
      bus.feat_valid = 1'b1;
      #1;
      chk("stream_feat_ready", bus.feat_ready, 1);
      step();
      if (i == 2) begin
        chk("bnd_stage_idx", bus.stage_idx, 1);
        chk("bnd_wc_idx", bus.wc_idx, 0);
      end
    end
    bus.feat_valid = 1'b0;
    repeat (3) step();
    chk("bnd_leaf_count", n_leaf - base, 7);

    // Backpressure: leaf_ready low for 5 cycles in a continuous stream.
    start_window(STD_W'($urandom));
    base = n_leaf;
    rand_feat();
    bus.feat_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.leaf_ready = (i >= 6 && i <= 10) ? 1'b0 : 1'b1;
      #1;
      if (i == 10) begin
        chk("bp_feat_ready", bus.feat_ready, 0);
        chk("bp_leaf_valid", bus.leaf_valid, 1);
      end
      if (i >= 11) chk("bp_resume_valid", bus.leaf_valid, 1);
      acc = int'(bus.feat_valid && bus.feat_ready);
      step();
      if (acc != 0) rand_feat();
    end
    bus.feat_valid = 1'b0;
    bus.leaf_ready = 1'b1;
    repeat (4) step();
    chk("bp_drain_empty", sb.size(), 0);
    chk("bp_leaf_count", n_leaf - base, n_acc);

    // Early reject: win_done with a feature offered and the third leaf in flight.
    start_window(16'd100);
    base = n_leaf;
    bus.leaf_ready = 1'b1;
    bus.feat_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_feat();
      step();
    end
    bus.feat_valid = 1'b0;
    step();
    rand_feat();
    bus.feat_valid = 1'b1;
    bus.win_done = 1'b1;
    bus.leaf_ready = 1'b0;
    #1;
    chk("rej_feat_offer_ready", bus.feat_ready, 1);
    step();
    bus.win_done = 1'b0;
    bus.feat_valid = 1'b0;
    bus.leaf_ready = 1'b1;
    chk("rej_leaf_valid", bus.leaf_valid, 0);
    chk("rej_std_ready", bus.std_ready, 1);
    chk("rej_feat_ready", bus.feat_ready, 0);
    chk("rej_stage_idx", bus.stage_idx, 0);
    chk("rej_wc_idx", bus.wc_idx, 0);
    step();
    step();
    chk("rej_no_late_leaf", bus.leaf_valid, 0);
    chk("rej_leaf_count", n_leaf - base, 2);

    // Full cascade with random features and random leaf_ready.
    start_window(STD_W'($urandom));
    base = n_leaf;
    rand_feat();
    bus.feat_valid = 1'b1;
    cyc = 0;
    while (n_acc < total && cyc < 20000) begin
      bus.leaf_ready = ($urandom_range(3) != 0);
      #1;
      acc = int'(bus.feat_valid && bus.feat_ready);
      step();
      if (acc != 0) rand_feat();
      cyc++;
    end
    chk("cascade_accepted", n_acc, total);
    #1;
    chk("done_feat_ready", bus.feat_ready, 0);
    chk("done_std_ready", bus.std_ready, 0);
    bus.leaf_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("done_no_extra_accept", n_acc, total);
    chk("cascade_drain_empty", sb.size(), 0);
    chk("cascade_leaf_count", n_leaf - base, total);
    bus.feat_valid = 1'b0;
    bus.win_done = 1'b1;
    step();
    bus.win_done = 1'b0;
    chk("post_done_std_ready", bus.std_ready, 1);
    bus.std_data = 16'd321;
    bus.std_valid = 1'b1;
    step();
    bus.std_valid = 1'b0;
    chk("new_window_feat_ready", bus.feat_ready, 1);
    chk("new_window_std_ready", bus.std_ready, 0);

    // Reset with both pipeline stages holding a nonzero leaf.
    bus.leaf_ready = 1'b0;
    bus.feat_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_feat();
      bus.feat_leaf_left = 13'sd77;
      bus.feat_leaf_right = 13'sd77;
      step();
    end
    bus.feat_valid = 1'b0;
    chk("full_feat_ready", bus.feat_ready, 0);
    chk("full_leaf_data", bus.leaf_data, 77);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_leaf_valid", bus.leaf_valid, 0);
    chk("mrst_leaf_data", bus.leaf_data, 0);
    chk("mrst_std_ready", bus.std_ready, 1);
    chk("mrst_feat_ready", bus.feat_ready, 0);
    chk("mrst_stage_idx", bus.stage_idx, 0);
    chk("mrst_wc_idx", bus.wc_idx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
